or1200_keccak_resp: RTL
=======================

Name: or1200_keccak_resp

Overview:
- Responder for the l.cust5 Keccak command stream issued by or1200_ctrl/or1200_cpu_keccak.
- Decodes start/middle/end absorb commands and forwards message words to the Keccak permutation core through a small FIFO.
- Captures the digest the core returns.
- Serves l.cust5 store commands, which read one digest word by index into the rf_dataw path.

Parameters:
- FIFO_DEPTH, 4, depth of the message-word FIFO toward the core (power of 2, >=2).
- DIGEST_WORDS, 16, number of 32-bit digest words captured (<=32).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  EX-stage l.cust5 valid, already qualified by ex_freeze
- cmd_op  in  5  cust5_op field: 00100 start, 00010 middle, 00001 end, 01000 store
- cmd_limm  in  6  cust5_limm field; digest word index for store
- cmd_a  in  32  operand A (message word for absorb ops)
- stall  out  1  request pipeline freeze; the command is held and re-presented
- rd_valid  out  1  store data valid
- rd_data  out  32  store read data, to WB/rf_dataw mux
- err  out  1  sticky protocol error
- core_wr  out  1  message word push to core
- core_wdata  out  32  message word
- core_first  out  1  marks the first word of a message
- core_last  out  1  marks the final word; core pads and finishes
- core_ready  in  1  core accepts a word this cycle
- core_abort  out  1  one-cycle pulse; core discards its state
- core_dvalid  in  1  digest word strobe from core, sequential from index 0
- core_dword  in  32  digest word

Behaviour:
- Reset values: stall=0, rd_valid=0, rd_data=0, err=0, core_wr=0, core_first=0, core_last=0, core_abort=0. FSM=IDLE, FIFO empty, digest buffer cleared to 0, capture index=0.
- FSM states: IDLE, ABSORB, WAIT_DIG, DONE.
- start:
  - Accepted in any state.
  - Outside IDLE/DONE it aborts: core_abort pulses, FIFO flushes, digest is cleared.
  - Pushes {cmd_a, first=1, last=0} and moves to ABSORB.
- middle:
  - Valid only in ABSORB. Pushes {cmd_a, 0, 0}.
  - In any other state it is ignored and sets err.
- end:
  - Valid only in ABSORB. Pushes {cmd_a, 0, 1}, moves to WAIT_DIG and resets the capture index.
  - In any other state it is ignored and sets err.
  - If start is immediately followed by end, the single word carries both first=1 and last=1.
- Absorb ops with FIFO full: stall=1 combinationally in the same cycle. The command is not consumed until space exists.
- FIFO drain:
  - core_wr = !empty. Head word is presented on core_wdata/core_first/core_last.
  - The word pops when core_wr && core_ready.
  - Push and pop in the same cycle on a full FIFO are allowed only if the pop frees the slot; stall is computed from the pre-pop count.
- Digest capture:
  - In WAIT_DIG, each core_dvalid writes core_dword into buf[idx] and increments idx.
  - After DIGEST_WORDS words the FSM moves to DONE.
  - core_dvalid in any other state is ignored.
- store:
  - Accepted only in DONE. In IDLE/ABSORB/WAIT_DIG, stall=1 until DONE.
  - Exception: store in IDLE sets err, returns rd_data=0 and does not stall.
  - rd_valid pulses exactly 1 cycle after acceptance.
  - rd_data = buf[cmd_limm] if cmd_limm < DIGEST_WORDS, else 0.
  - rd_data holds its value until the next store.
  - Stores do not change state; repeated reads are allowed.
- Unknown cmd_op (anything not listed): no effect, no stall, err set.
- err clears only on rst or on an accepted start.
- rst mid-operation: all state returns to reset values. core_abort is not pulsed; the core shares rst.

Optional Feature:
- Macro OR1200_KECCAK_RESP_PERF_EN.
- Defined:
  - 32-bit cycle counter clears on accepted start, counts every cycle in ABSORB and WAIT_DIG, and freezes on entry to DONE.
  - store with cmd_limm=63 returns the counter value.
- Undefined: no counter logic; limm=63 returns 0 like any out-of-range index.

Test Plan:
- Reset, then start a=1, middle a=2, end a=3 with core_ready=1 → core sees words 1,2,3; core_first only on word 1; core_last only on word 3; FSM reaches WAIT_DIG; stall never asserted.
- Core returns 16 words 0xA0..0xAF, then stores with limm 15 down to 0 → rd_valid 1 cycle after each store; rd_data=0xAF..0xA0 in order; store limm=20 → 0.
- core_ready=0 with FIFO_DEPTH=4, issue start plus 4 middles → 5th absorb sees stall=1 until core_ready=1 pops one word; word order is preserved.
- Store issued during WAIT_DIG after 5 of 16 digest words → stall held until the 16th core_dvalid; store data is correct the cycle after release.
- middle a=7 from IDLE → err=1, no core_wr; a following start clears err. A second start during ABSORB → core_abort pulses 1 cycle and the FIFO holds only the new first word.
- With OR1200_KECCAK_RESP_PERF_EN: 3-word message, core_ready=1, digest returned 10 cycles after the last pop → store limm=63 returns the exact ABSORB+WAIT_DIG cycle count. Without the macro → limm=63 returns 0.

Source files
------------

// File: rtl/or1200_keccak_resp.sv
// Responder for the l.cust5 Keccak command stream: feeds message words to the core, captures the digest, serves stores.
// Optional build macro OR1200_KECCAK_RESP_PERF_EN adds a cycle counter readable at store index 63.
module or1200_keccak_resp #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DIGEST_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [4:0]  cmd_op,
    input  logic [5:0]  cmd_limm,
    input  logic [31:0] cmd_a,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        err,
    output logic        core_wr,
    output logic [31:0] core_wdata,
    output logic        core_first,
    output logic        core_last,
    input  logic        core_ready,
    output logic        core_abort,
    input  logic        core_dvalid,
    input  logic [31:0] core_dword,
    output logic [1:0]  fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DIGEST_WORDS);

    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;

    typedef enum logic [1:0] {IDLE = 2'd0, ABSORB = 2'd1, WAIT_DIG = 2'd2, DONE = 2'd3} state_t;

    // Handshakes: a command is consumed on a rising edge where cmd_valid=1 and stall=0;
    // a FIFO word transfers to the core on a rising edge where core_wr=1 and core_ready=1.
    state_t state, next_state;

    logic [33:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, pop;

    logic [31:0]   dig [DIGEST_WORDS];
    logic [IW-1:0] cap_idx;

    logic push, push_first, push_last, abort, set_err, start_acc;
    logic store_acc, store_idle, cap_wr, cap_reset;
    logic [31:0] rd_word;

    assign fsm_state = state;
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign core_wr   = (count != '0);
    assign pop       = core_wr && core_ready;
    assign {core_wdata, core_first, core_last} = fifo_mem[rd_ptr];

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        push       = 1'b0;
        push_first = 1'b0;
        push_last  = 1'b0;
        abort      = 1'b0;
        set_err    = 1'b0;
        start_acc  = 1'b0;
        store_acc  = 1'b0;
        store_idle = 1'b0;
        cap_wr     = 1'b0;
        cap_reset  = 1'b0;
        if (cmd_valid) begin
            case (cmd_op)
                OP_START: begin
                    // An aborting start flushes the FIFO, so it never has to wait for space.
                    abort = (state == ABSORB) || (state == WAIT_DIG);
                    if (full && !abort) begin
                        stall = 1'b1;
                    end else begin
                        start_acc  = 1'b1;
                        push       = 1'b1;
                        push_first = 1'b1;
                        next_state = ABSORB;
                    end
                end
                OP_MIDDLE: begin
                    if (state != ABSORB)  set_err = 1'b1;
                    else if (full)        stall   = 1'b1;
                    else                  push    = 1'b1;
                end
                OP_END: begin
                    if (state != ABSORB) begin
                        set_err = 1'b1;
                    end else if (full) begin
                        stall = 1'b1;
                    end else begin
                        push       = 1'b1;
                        push_last  = 1'b1;
                        cap_reset  = 1'b1;
                        next_state = WAIT_DIG;
                    end
                end
                OP_STORE: begin
                    case (state)
                        DONE:    store_acc = 1'b1;
                        IDLE: begin
                            store_idle = 1'b1;
                            set_err    = 1'b1;
                        end
                        default: stall = 1'b1;
                    endcase
                end
                default: set_err = 1'b1;
            endcase
        end
        if (state == WAIT_DIG && core_dvalid && !abort) begin
            cap_wr = 1'b1;
            if (cap_idx == IW'(DIGEST_WORDS - 1)) next_state = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(1);
            count  <= (AW+1)'(1);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[abort ? '0 : wr_ptr] <= {cmd_a, push_first, push_last};
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            for (int i = 0; i < DIGEST_WORDS; i++) dig[i] <= '0;
        end else if (cap_wr) begin
            dig[cap_idx] <= core_dword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort || cap_reset) cap_idx <= '0;
        else if (cap_wr)               cap_idx <= cap_idx + IW'(1);
    end

`ifdef OR1200_KECCAK_RESP_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst || start_acc)                          perf_cnt <= '0;
        else if (state == ABSORB || state == WAIT_DIG) perf_cnt <= perf_cnt + 32'd1;
    end

    always_comb begin
        rd_word = '0;
        if ({26'd0, cmd_limm} < 32'(DIGEST_WORDS)) rd_word = dig[cmd_limm[IW-1:0]];
        else if (cmd_limm == 6'd63)                rd_word = perf_cnt;
    end
`else
    always_comb begin
        rd_word = '0;
        if ({26'd0, cmd_limm} < 32'(DIGEST_WORDS)) rd_word = dig[cmd_limm[IW-1:0]];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            err        <= 1'b0;
            core_abort <= 1'b0;
        end else begin
            rd_valid   <= store_acc || store_idle;
            core_abort <= abort;
            if (store_acc)       rd_data <= rd_word;
            else if (store_idle) rd_data <= '0;
            if (start_acc)       err <= 1'b0;
            else if (set_err)    err <= 1'b1;
        end
    end

endmodule
